cacheline_adapter: RTL and testbench
====================================

# cacheline_adapter

Converts a single 256-bit cache-line transaction from the memory-side port of the cache arbiter into a 4-beat, 64-bit burst on the banked main-memory (bmem) interface. It sits directly downstream of the arbiter: its upstream port is the arbiter's dfp_* port and its downstream port drives memory. One transaction is in flight at a time; completion is signalled upstream with a single-cycle response.

## Interface
- LINE_BITS, 256, cache-line width; upstream data width.
- BEAT_BITS, 64, memory beat width; BURST_LEN = LINE_BITS/BEAT_BITS (4) is derived, not a parameter.
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- dfp_addr  in  32  line address from the arbiter; bits [4:0] ignored.
- dfp_read  in  1  line read request; held until dfp_resp.
- dfp_write  in  1  line write request; held until dfp_resp.
- dfp_wdata  in  LINE_BITS  write line.
- dfp_rdata  out  LINE_BITS  assembled read line; valid in the dfp_resp cycle.
- dfp_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  32  line-aligned burst address ({addr[31:5],5'b0}).
- bmem_read  out  1  burst-read command, one accepted cycle per burst.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_BITS  current write beat.
- bmem_ready  in  1  memory accepts command/beat this cycle.
- bmem_raddr  in  32  address tag of the returning read beat.
- bmem_rdata  in  BEAT_BITS  read beat.
- bmem_rvalid  in  1  read beat valid.
- err  out  1  sticky protocol-error flag (see Configuration).

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_DATA, RESP.
- IDLE: if dfp_read, latch the aligned address and go to RD_REQ. Otherwise, if dfp_write, latch the address and dfp_wdata and go to WR_DATA. If both are asserted, the read wins; both asserted at once is an illegal upstream condition.
- RD_REQ: drive bmem_read=1 and bmem_addr. When bmem_ready=1, the command is accepted; clear the beat counter and go to RD_DATA.
- RD_DATA: on each bmem_rvalid, write bmem_rdata into line bits [64*k+63:64*k], where k is the 2-bit beat counter, then increment k. On the beat with k=3, go to RESP.
- WR_DATA: drive bmem_write=1, bmem_addr, and bmem_wdata = latched line bits [64*k+63:64*k]. k increments only on cycles where bmem_ready=1. The beat with k=3 accepted → RESP.
- RESP: dfp_resp=1 for exactly one cycle, then IDLE. The RESP→IDLE cycle does not re-sample dfp_read/dfp_write.
- Ignored inputs: bmem_rvalid outside RD_DATA; bmem_ready outside RD_REQ/WR_DATA.
- Beat counter wraps 3→0 at the end of each burst. Beat order is always 0..3 (ascending address).
- Reset, including mid-burst: state=IDLE, k=0, and outputs go to their reset values on the next edge. The in-flight transaction is dropped. Late beats arriving in IDLE are ignored.

## Timing
- Reset values: dfp_resp=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, dfp_rdata=0, err=0.
- All outputs are decoded from registered state/datapath; there is no combinational path from dfp_* to bmem_*.
- Read: request seen at edge 0 → bmem_read high in cycle 1. With memory latency L after acceptance and back-to-back beats, dfp_resp is high in the cycle after the 4th beat. Minimum is 1+L+4+1 cycles.
- Write: request at edge 0 → beats in cycles 1–4 (bmem_ready=1 throughout) → dfp_resp in cycle 5. Each bmem_ready=0 cycle adds one cycle.
- dfp_rdata holds its value after RESP until the next read completes.

## Configuration
- CACHELINE_ADAPTER_RADDR_CHECK_EN defined: in RD_DATA, a beat whose bmem_raddr[31:5] ≠ latched address [31:5] is not stored and not counted, and err is set. err stays sticky until reset.
- Undefined: bmem_raddr is ignored and err is tied to 0.

## Structure
- Shared package mem_types_pkg: LINE_BITS, BEAT_BITS, BURST_LEN, and the adapter state enum type.
- Sub-module line_beat_buffer: a LINE_BITS register with beat-indexed write (for reads) and a beat-indexed read mux (for writes). The FSM, counter and latch stay in cacheline_adapter.

## Test plan
- Read, addr 0x1234_5678, memory returns beats 0xA0..0xA3 after L=3 → bmem_addr=0x1234_5660, one bmem_read handshake, dfp_rdata={A3,A2,A1,A0} with dfp_resp high exactly one cycle.
- Write, wdata = {D3,D2,D1,D0}, bmem_ready=1 → bmem_write cycles 1–4 carrying D0..D3, dfp_resp in cycle 5.
- Write with bmem_ready low on beat 2 for 3 cycles → beat 2 held stable with no duplicate counting; dfp_resp delayed to cycle 8.
- Read and write asserted together → read burst issued, no bmem_write. Also: rvalid pulses in IDLE → ignored, state unchanged.
- rst=0 asserted after beat 1 of a read → next cycle IDLE, all outputs zero, no dfp_resp. Remaining beats ignored; a following read completes correctly.
- With CACHELINE_ADAPTER_RADDR_CHECK_EN, inject one beat with a wrong raddr → beat discarded, err=1, and the line completes after 4 good beats.

Source files
------------

// File: rtl/mem_types_pkg.sv
// Shared widths and the adapter state type for the cache-line to bmem burst path.
package mem_types_pkg;

   localparam int LINE_BITS     = 256;
   localparam int BEAT_BITS     = 64;
   localparam int BURST_LEN     = LINE_BITS / BEAT_BITS;
   localparam int BEAT_IDX_BITS = $clog2(BURST_LEN);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_DATA,
      WR_DATA,
      RESP
   } adapter_state_e;

endpackage

// File: rtl/line_beat_buffer.sv
// One cache line of storage: whole-line load for writes, beat-indexed fill for reads,
// and a beat-indexed read mux feeding the outgoing write beat.
module line_beat_buffer
   import mem_types_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic [LINE_BITS-1:0]     load_line,
   input  logic                     beat_we,
   input  logic [BEAT_IDX_BITS-1:0] beat_idx,
   input  logic [BEAT_BITS-1:0]     beat_wdata,
   output logic [LINE_BITS-1:0]     line,
   output logic [BEAT_BITS-1:0]     beat_rdata
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         line <= '0;
      end else if (load) begin
         line <= load_line;
      end else if (beat_we) begin
         line[beat_idx*BEAT_BITS +: BEAT_BITS] <= beat_wdata;
      end
   end

   assign beat_rdata = line[beat_idx*BEAT_BITS +: BEAT_BITS];

endmodule

// File: rtl/cacheline_adapter.sv
// Turns one 256-bit arbiter line transaction into a 4-beat 64-bit bmem burst.
// Optional: CACHELINE_ADAPTER_RADDR_CHECK_EN drops read beats with a foreign address tag and sets sticky err.
module cacheline_adapter
   import mem_types_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          dfp_addr,
   input  logic                 dfp_read,
   input  logic                 dfp_write,
   input  logic [LINE_BITS-1:0] dfp_wdata,
   output logic [LINE_BITS-1:0] dfp_rdata,
   output logic                 dfp_resp,
   output logic [31:0]          bmem_addr,
   output logic                 bmem_read,
   output logic                 bmem_write,
   output logic [BEAT_BITS-1:0] bmem_wdata,
   input  logic                 bmem_ready,
   input  logic [31:0]          bmem_raddr,
   input  logic [BEAT_BITS-1:0] bmem_rdata,
   input  logic                 bmem_rvalid,
   output logic                 err
);

   adapter_state_e             state, next_state;
   logic [31:0]                addr_q;
   logic [BEAT_IDX_BITS-1:0]   beat_cnt;
   logic [LINE_BITS-1:0]       rdata_q;
   logic [LINE_BITS-1:0]       line;
   logic [BEAT_BITS-1:0]       beat_rdata;
   logic                       tag_ok;
   logic                       beat_ok;
   logic                       last_beat;
   logic                       unused_bits;

   assign unused_bits = ^{dfp_addr[4:0], bmem_raddr};

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
   logic err_q;

   assign tag_ok = (bmem_raddr[31:5] == addr_q[31:5]);

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (state == RD_DATA && bmem_rvalid && !tag_ok) begin
         err_q <= 1'b1;
      end
   end
`else
   logic err_q;

   assign tag_ok = 1'b1;
   assign err_q  = 1'b0;
`endif

   assign beat_ok   = (state == RD_DATA) && bmem_rvalid && tag_ok;
   assign last_beat = (beat_cnt == BEAT_IDX_BITS'(BURST_LEN - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (dfp_read) begin
               next_state = RD_REQ;
            end else if (dfp_write) begin
               next_state = WR_DATA;
            end
         end
         RD_REQ:  if (bmem_ready) next_state = RD_DATA;
         RD_DATA: if (beat_ok && last_beat) next_state = RESP;
         WR_DATA: if (bmem_ready && last_beat) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The finished read line is captured in its own register so writes and later
   // partial fills never disturb what the arbiter last read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_q   <= '0;
         beat_cnt <= '0;
         rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               beat_cnt <= '0;
               if (dfp_read || dfp_write) begin
                  addr_q <= {dfp_addr[31:5], 5'b0};
               end
            end
            RD_REQ: begin
               if (bmem_ready) beat_cnt <= '0;
            end
            RD_DATA: begin
               if (beat_ok) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (last_beat) begin
                     rdata_q <= {bmem_rdata, line[LINE_BITS-BEAT_BITS-1:0]};
                  end
               end
            end
            WR_DATA: begin
               if (bmem_ready) beat_cnt <= beat_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   line_beat_buffer u_buf (
      .clk        (clk),
      .rst        (rst),
      .load       (state == IDLE && !dfp_read && dfp_write),
      .load_line  (dfp_wdata),
      .beat_we    (beat_ok),
      .beat_idx   (beat_cnt),
      .beat_wdata (bmem_rdata),
      .line       (line),
      .beat_rdata (beat_rdata)
   );

   always_comb begin
      dfp_resp   = 1'b0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_wdata = '0;
      bmem_addr  = addr_q;
      dfp_rdata  = rdata_q;
      err        = err_q;
      case (state)
         RD_REQ:  bmem_read = 1'b1;
         WR_DATA: begin
            bmem_write = 1'b1;
            bmem_wdata = beat_rdata;
         end
         RESP:    dfp_resp = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reads, writes, stalls, priority, reset mid-burst.
// Define CACHELINE_ADAPTER_RADDR_CHECK_EN to also exercise the read-address tag check.
module tb_cacheline_adapter;

   logic         clk;
   logic         rst;
   logic [31:0]  dfp_addr;
   logic         dfp_read;
   logic         dfp_write;
   logic [255:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready;
   logic [31:0]  bmem_raddr;
   logic [63:0]  bmem_rdata;
   logic         bmem_rvalid;
   logic         err;

   int errors = 0;
   int checks = 0;

   cacheline_adapter dut (
      .clk         (clk),
      .rst         (rst),
      .dfp_addr    (dfp_addr),
      .dfp_read    (dfp_read),
      .dfp_write   (dfp_write),
      .dfp_wdata   (dfp_wdata),
      .dfp_rdata   (dfp_rdata),
      .dfp_resp    (dfp_resp),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pat(input logic [7:0] b);
      return {8{b}};
   endfunction

   // Inputs are applied at a negedge (seen at the next posedge); returns at the following negedge.
   task automatic applyStimulus(input logic r_n, input logic rd, input logic wr, input logic rdy,
                                input logic rv, input logic [63:0] rdat, input logic [31:0] radr);
      rst         = r_n;
      dfp_read    = rd;
      dfp_write   = wr;
      bmem_ready  = rdy;
      bmem_rvalid = rv;
      bmem_rdata  = rdat;
      bmem_raddr  = radr;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_resp"},   256'(dfp_resp),   256'd0);
      checkOutput({tag, "_bread"},  256'(bmem_read),  256'd0);
      checkOutput({tag, "_bwrite"}, 256'(bmem_write), 256'd0);
      checkOutput({tag, "_baddr"},  256'(bmem_addr),  256'd0);
      checkOutput({tag, "_bwdata"}, 256'(bmem_wdata), 256'd0);
      checkOutput({tag, "_rdata"},  dfp_rdata,        256'd0);
      checkOutput({tag, "_err"},    256'(err),        256'd0);
   endtask

   initial begin
      logic [255:0] line_a, line_c, line_g, wline_d, wline_e;
      logic [63:0]  e_beats [4];
      int           exp_idx [7];
      logic         rdy_seq [7];

      line_a  = {pat(8'hA3), pat(8'hA2), pat(8'hA1), pat(8'hA0)};
      line_c  = {pat(8'hC3), pat(8'hC2), pat(8'hC1), pat(8'hC0)};
      line_g  = {pat(8'h73), pat(8'h72), pat(8'h71), pat(8'h70)};
      wline_d = {pat(8'hD3), pat(8'hD2), pat(8'hD1), pat(8'hD0)};
      wline_e = {pat(8'hE3), pat(8'hE2), pat(8'hE1), pat(8'hE0)};
      e_beats = '{pat(8'hE0), pat(8'hE1), pat(8'hE2), pat(8'hE3)};
      exp_idx = '{0, 1, 2, 2, 2, 2, 3};
      rdy_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

      dfp_addr  = '0;
      dfp_wdata = '0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0);
      checkAllZero("reset");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);

      // Read 0x1234_5678, latency 3, beats A0..A3
      dfp_addr = 32'h1234_5678;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      checkOutput("rd_bread_c1", 256'(bmem_read), 256'd1);
      checkOutput("rd_baddr",    256'(bmem_addr), 256'h1234_5660);
      checkOutput("rd_bwrite",   256'(bmem_write), 256'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      checkOutput("rd_bread_once", 256'(bmem_read), 256'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      checkOutput("rd_lat_resp", 256'(dfp_resp), 256'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, pat(8'hA0 + 8'(i)), 32'h1234_5660 + 32'(8 * i));
         if (i < 3) checkOutput("rd_resp_early", 256'(dfp_resp), 256'd0);
      end
      checkOutput("rd_resp",  256'(dfp_resp), 256'd1);
      checkOutput("rd_rdata", dfp_rdata, line_a);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      checkOutput("rd_resp_pulse", 256'(dfp_resp), 256'd0);
      checkOutput("rd_rdata_hold", dfp_rdata, line_a);

      // Write D0..D3 with memory always ready
      dfp_addr  = 32'h0000_ABCD;
      dfp_wdata = wline_d;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 32'd0);
      checkOutput("wr_baddr", 256'(bmem_addr), 256'h0000_ABC0);
      for (int n = 0; n < 4; n++) begin
         checkOutput("wr_bwrite", 256'(bmem_write), 256'd1);
         checkOutput("wr_bwdata", 256'(bmem_wdata), 256'(pat(8'hD0 + 8'(n))));
         checkOutput("wr_resp_early", 256'(dfp_resp), 256'd0);
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 32'd0);
      end
      checkOutput("wr_resp_c5",   256'(dfp_resp), 256'd1);
      checkOutput("wr_bwrite_c5", 256'(bmem_write), 256'd0);
      checkOutput("wr_rdata_kept", dfp_rdata, line_a);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      checkOutput("wr_resp_pulse", 256'(dfp_resp), 256'd0);

      // Write with bmem_ready low for 3 cycles on beat 2
      dfp_addr  = 32'h0000_0100;
      dfp_wdata = wline_e;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 32'd0);
      for (int c = 0; c < 7; c++) begin
         checkOutput("st_bwrite", 256'(bmem_write), 256'd1);
         checkOutput("st_bwdata", 256'(bmem_wdata), 256'(e_beats[exp_idx[c]]));
         checkOutput("st_resp_early", 256'(dfp_resp), 256'd0);
         applyStimulus(1'b1, 1'b0, 1'b1, rdy_seq[c], 1'b0, 64'd0, 32'd0);
      end
      checkOutput("st_resp_c8", 256'(dfp_resp), 256'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);

      // Read and write together: read wins
      dfp_addr  = 32'h0000_1000;
      dfp_wdata = wline_d;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 32'd0);
      checkOutput("rw_bread",  256'(bmem_read), 256'd1);
      checkOutput("rw_bwrite", 256'(bmem_write), 256'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("rw_bwrite_burst", 256'(bmem_write), 256'd0);
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, pat(8'hC0 + 8'(i)), 32'h0000_1000 + 32'(8 * i));
      end
      checkOutput("rw_resp",  256'(dfp_resp), 256'd1);
      checkOutput("rw_rdata", dfp_rdata, line_c);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);

      // Stray rvalid in IDLE
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pat(8'h55), 32'h0000_1000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pat(8'h66), 32'h0000_1008);
      checkOutput("idle_rv_resp",  256'(dfp_resp), 256'd0);
      checkOutput("idle_rv_bread", 256'(bmem_read), 256'd0);
      checkOutput("idle_rv_rdata", dfp_rdata, line_c);

      // Reset after beat 1 of a read
      dfp_addr = 32'h0000_2040;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, pat(8'hF0), 32'h0000_2040);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, pat(8'hF1), 32'h0000_2048);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      checkAllZero("midrst");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pat(8'hF2), 32'h0000_2050);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pat(8'hF3), 32'h0000_2058);
      checkOutput("late_resp",  256'(dfp_resp), 256'd0);
      checkOutput("late_bread", 256'(bmem_read), 256'd0);
      checkOutput("late_rdata", dfp_rdata, 256'd0);

      dfp_addr = 32'h0000_3000;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      checkOutput("post_bread", 256'(bmem_read), 256'd1);
      checkOutput("post_baddr", 256'(bmem_addr), 256'h0000_3000);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, pat(8'h70 + 8'(i)), 32'h0000_3000 + 32'(8 * i));
      end
      checkOutput("post_resp",  256'(dfp_resp), 256'd1);
      checkOutput("post_rdata", dfp_rdata, line_g);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
      // One beat with a foreign tag is discarded and flags err
      dfp_addr = 32'h0000_4000;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, pat(8'h70), 32'h0000_4000);
      checkOutput("tag_err_before", 256'(err), 256'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, pat(8'hBB), 32'h0000_9008);
      checkOutput("tag_err_set", 256'(err), 256'd1);
      for (int i = 1; i < 4; i++) begin
         checkOutput("tag_resp_early", 256'(dfp_resp), 256'd0);
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, pat(8'h70 + 8'(i)), 32'h0000_4000 + 32'(8 * i));
      end
      checkOutput("tag_resp",  256'(dfp_resp), 256'd1);
      checkOutput("tag_rdata", dfp_rdata, line_g);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0);
      checkOutput("tag_err_sticky", 256'(err), 256'd1);
`else
      checkOutput("err_tied_low", 256'(err), 256'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
